red_pitaya_asg_top: RTL and testbench

RED_PITAYA_ASG_TOP -- requirements
Module: red_pitaya_asg_top

---
 rtl/red_pitaya_asg_pkg.sv | 27 ++
 rtl/asg_bus_if.sv | 22 ++
 rtl/asg_ram.sv | 40 ++++
 rtl/red_pitaya_asg_top.sv | 245 ++++++++++++++++++++++++
 tb/tb_red_pitaya_asg_top.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/red_pitaya_asg_pkg.sv
// Red Pitaya arbitrary signal generator: shared constants.
// Register map offsets and generator state encoding.
package red_pitaya_asg_pkg;

  localparam int DWM_DEF = 14;
  localparam int CWM_DEF = 14;
  localparam int CWF_DEF = 16;

  localparam logic [16:0] REG_CTL   = 17'h00;
  localparam logic [16:0] REG_TRG   = 17'h04;
  localparam logic [16:0] REG_SIZE  = 17'h10;
  localparam logic [16:0] REG_OFFS  = 17'h14;
  localparam logic [16:0] REG_STEP  = 17'h18;
  localparam logic [16:0] REG_BURST = 17'h20;
  localparam logic [16:0] REG_BDL   = 17'h24;
  localparam logic [16:0] REG_BIL   = 17'h28;
  localparam logic [16:0] REG_BRN   = 17'h2c;
  localparam logic [16:0] REG_AMP   = 17'h38;
  localparam logic [16:0] REG_DCO   = 17'h3c;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAUSE
  } asg_state_e;

endpackage

// File: rtl/asg_bus_if.sv
// Generator system bus: single-cycle strobes,
// acknowledge and read data one cycle later.
interface asg_bus_if;

  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_ack
  );

endinterface

// File: rtl/asg_ram.sv
// Waveform table: dual-port RAM, port A for the bus,
// port B for the generator, registered reads on both.
module asg_ram #(
  parameter int AW = 14,
  parameter int DW = 14
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic [AW-1:0] b_addr_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem[a_addr_i] <= a_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem[a_addr_i];
      b_rdata_q <= mem[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/red_pitaya_asg_top.sv
// Arbitrary signal generator: phase accumulator over a
// waveform table, burst sequencing, gain/offset output.
module red_pitaya_asg_top
  import red_pitaya_asg_pkg::*;
#(
  parameter int DWM = DWM_DEF,
  parameter int CWM = CWM_DEF,
  parameter int CWF = CWF_DEF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  trig_i,
  asg_bus_if.slave              bus,
  output logic signed [DWM-1:0] dac_o
);

  localparam int CW = CWM + CWF;
  localparam int MW = 2 * DWM + 1;
  localparam int SW = MW + 1;
  localparam logic signed [SW-1:0] SMAX =
    SW'((1 << (DWM - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  logic [16:0] addr;
  logic tbl_sel, reg_wr, reg_rd;
  logic stop, start, go;

  asg_state_e state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW:0] ptr_sum, ptr_wrap;
  logic [CW-1:0] size_q, size_d;
  logic [CW-1:0] offs_q, offs_d;
  logic [CW-1:0] step_q, step_d;
  logic [2:0] trg_q, trg_d;
  logic [1:0] burst_q, burst_d;
  logic [15:0] bdl_q, bdl_d;
  logic [15:0] bil_q, bil_d;
  logic [15:0] brn_q, brn_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] per_q, per_d;
  logic [DWM-1:0] amp_q, amp_d;
  logic signed [DWM-1:0] dco_q, dco_d;
  logic trig_q, ack_q, tbl_rd_q, vld_q;
  logic [31:0] rdata_q, rdata_d;

  logic signed [DWM-1:0] a_rdata, b_rdata, smp;
  logic signed [MW-1:0] mul_q, mul_d;
  logic signed [SW-1:0] sum;
  logic signed [DWM-1:0] dac_q, dac_d;
  logic unused_bits;

  assign addr    = bus.sys_addr[16:0];
  assign tbl_sel = addr[16];
  assign reg_wr  = bus.sys_wen & ~tbl_sel;
  assign reg_rd  = bus.sys_ren & ~tbl_sel;
  assign unused_bits = ^{bus.sys_addr[31:17],
                         bus.sys_wdata[31:CW]};

  asg_ram #(
    .AW(CWM),
    .DW(DWM)
  ) u_ram (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .a_we_i   (bus.sys_wen & tbl_sel),
    .a_addr_i (bus.sys_addr[CWM+1:2]),
    .a_wdata_i(bus.sys_wdata[DWM-1:0]),
    .a_rdata_o(a_rdata),
    .b_addr_i (ptr_q[CW-1:CWF]),
    .b_rdata_o(b_rdata)
  );

  always_comb begin
    trg_d   = trg_q;
    size_d  = size_q;
    offs_d  = offs_q;
    step_d  = step_q;
    burst_d = burst_q;
    bdl_d   = bdl_q;
    bil_d   = bil_q;
    brn_d   = brn_q;
    amp_d   = amp_q;
    dco_d   = dco_q;
    stop    = 1'b0;
    start   = 1'b0;
    if (reg_wr) begin
      unique case (1'b1)
        addr == REG_CTL: begin
          stop  = bus.sys_wdata[0];
          start = bus.sys_wdata[1];
        end
        addr == REG_TRG:   trg_d   = bus.sys_wdata[2:0];
        addr == REG_SIZE:  size_d  = bus.sys_wdata[CW-1:0];
        addr == REG_OFFS:  offs_d  = bus.sys_wdata[CW-1:0];
        addr == REG_STEP:  step_d  = bus.sys_wdata[CW-1:0];
        addr == REG_BURST: burst_d = bus.sys_wdata[1:0];
        addr == REG_BDL:   bdl_d   = bus.sys_wdata[15:0];
        addr == REG_BIL:   bil_d   = bus.sys_wdata[15:0];
        addr == REG_BRN:   brn_d   = bus.sys_wdata[15:0];
        addr == REG_AMP:   amp_d   = bus.sys_wdata[DWM-1:0];
        addr == REG_DCO:   dco_d   = bus.sys_wdata[DWM-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (reg_rd) begin
      unique case (1'b1)
        addr == REG_CTL:   rdata_d = {31'b0, state_q != ST_IDLE};
        addr == REG_TRG:   rdata_d = {29'b0, trg_q};
        addr == REG_SIZE:  rdata_d = 32'(size_q);
        addr == REG_OFFS:  rdata_d = 32'(offs_q);
        addr == REG_STEP:  rdata_d = 32'(step_q);
        addr == REG_BURST: rdata_d = {30'b0, burst_q};
        addr == REG_BDL:   rdata_d = {16'b0, bdl_q};
        addr == REG_BIL:   rdata_d = {16'b0, bil_q};
        addr == REG_BRN:   rdata_d = {16'b0, brn_q};
        addr == REG_AMP:   rdata_d = 32'(amp_q);
        addr == REG_DCO:   rdata_d = 32'(dco_q);
        default: ;
      endcase
    end
  end

  // Table reads bypass rdata_q: the RAM already adds the cycle.
  assign bus.sys_rdata = tbl_rd_q ? 32'(a_rdata) : rdata_q;
  assign bus.sys_ack   = ack_q;

  assign go = (start & trg_q[0])
            | (trig_i & ~trig_q & trg_q[1])
            | (~trig_i & trig_q & trg_q[2]);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cyc_d    = cyc_q;
    per_d    = per_q;
    ptr_sum  = {1'b0, ptr_q} + {1'b0, step_q}
             + {{CW{1'b0}}, 1'b1};
    ptr_wrap = ptr_sum - {1'b0, size_q}
             - {{CW{1'b0}}, 1'b1};
    unique case (state_q)
      ST_IDLE: begin
        if (go && !stop) begin
          state_d = ST_DATA;
          ptr_d   = offs_q;
          cyc_d   = '0;
          per_d   = '0;
        end
      end
      ST_DATA: begin
        ptr_d = (ptr_sum > {1'b0, size_q}) ?
                ptr_wrap[CW-1:0] : ptr_sum[CW-1:0];
        if (burst_q[0]) begin
          if (cyc_q == bdl_q) begin
            cyc_d   = '0;
            per_d   = per_q + 16'd1;
            state_d = (per_q == brn_q && !burst_q[1]) ?
                      ST_IDLE : ST_PAUSE;
          end else begin
            cyc_d = cyc_q + 16'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (cyc_q == bil_q) begin
          state_d = ST_DATA;
          ptr_d   = offs_q;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    smp   = vld_q ? b_rdata : '0;
    mul_d = MW'(smp) * MW'($signed({1'b0, amp_q}));
    sum   = SW'(mul_q >>> (DWM - 2)) + SW'(dco_q);
    dac_d = sum[DWM-1:0];
    if (sum > SMAX) begin
      dac_d = SMAX[DWM-1:0];
    end else if (sum < SMIN) begin
      dac_d = SMIN[DWM-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      size_q   <= '0;
      offs_q   <= '0;
      step_q   <= '0;
      trg_q    <= '0;
      burst_q  <= '0;
      bdl_q    <= '0;
      bil_q    <= '0;
      brn_q    <= '0;
      cyc_q    <= '0;
      per_q    <= '0;
      amp_q    <= '0;
      dco_q    <= '0;
      trig_q   <= 1'b0;
      ack_q    <= 1'b0;
      tbl_rd_q <= 1'b0;
      rdata_q  <= '0;
      vld_q    <= 1'b0;
      mul_q    <= '0;
      dac_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      size_q   <= size_d;
      offs_q   <= offs_d;
      step_q   <= step_d;
      trg_q    <= trg_d;
      burst_q  <= burst_d;
      bdl_q    <= bdl_d;
      bil_q    <= bil_d;
      brn_q    <= brn_d;
      cyc_q    <= cyc_d;
      per_q    <= per_d;
      amp_q    <= amp_d;
      dco_q    <= dco_d;
      trig_q   <= trig_i;
      ack_q    <= bus.sys_wen | bus.sys_ren;
      tbl_rd_q <= bus.sys_ren & tbl_sel;
      rdata_q  <= rdata_d;
      vld_q    <= state_q == ST_DATA;
      mul_q    <= mul_d;
      dac_q    <= dac_d;
    end
  end

  assign dac_o = dac_q;

endmodule

// File: tb/tb_red_pitaya_asg_top.sv
// Directed bench for the signal generator: bus access,
// streaming, wrap, stop, saturation, triggers, bursts, reset.
module tb_red_pitaya_asg_top;
  import red_pitaya_asg_pkg::*;

  localparam logic [31:0] TBL = 32'h10000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic trig = 1'b0;
  logic signed [13:0] dac;
  logic [31:0] rd_data;
  logic rd_ack;
  int n_chk = 0;
  int n_err = 0;
  int exp_b [14] = '{0, 0, 5, 6, 7, 8, 0, 0,
                     5, 6, 7, 8, 0, 0};

  asg_bus_if bus ();

  red_pitaya_asg_top dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .trig_i(trig),
    .bus   (bus),
    .dac_o (dac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    @(negedge clk);
    bus.sys_wen   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge clk);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    @(posedge clk);
    #1;
    rd_data = bus.sys_rdata;
    rd_ack  = bus.sys_ack;
    @(negedge clk);
    bus.sys_ren = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    tick(1);
    chk("rst_dac", 32'(dac), 0);
    chk("rst_ack", 32'(bus.sys_ack), 0);
    chk("rst_rdata", bus.sys_rdata, 0);
    rd(32'(REG_SIZE));
    chk("rst_size", rd_data, 0);

    for (int i = 0; i < 256; i++) begin
      wr(TBL + 32'(4 * i), 32'(i));
    end
    wr(TBL + 32'(4 * 300), 32'h3fff);
    wr(32'(REG_AMP), 4096);
    wr(32'(REG_DCO), 0);
    wr(32'(REG_SIZE), 32'h00ffffff);
    wr(32'(REG_STEP), 65535);
    wr(32'(REG_TRG), 1);

    rd(32'(REG_SIZE));
    chk("size_rd", rd_data, 32'h00ffffff);
    chk("size_ack", 32'(rd_ack), 1);
    tick(1);
    chk("ack_drop", 32'(bus.sys_ack), 0);
    rd(TBL + 32'(4 * 300));
    chk("tbl_neg", rd_data, 32'hffffffff);
    rd(TBL + 32'(4 * 7));
    chk("tbl_pos", rd_data, 7);

    wr(32'(REG_CTL), 2);
    for (int e = 1; e <= 260; e++) begin
      tick(1);
      if (e == 3 || e == 4 || e == 5 || e == 100 ||
          e == 258 || e == 259 || e == 260) begin
        chk($sformatf("stream_e%0d", e), 32'(dac),
            32'((e - 3) % 256));
      end
    end
    rd(32'(REG_CTL));
    chk("running", rd_data, 1);

    wr(32'(REG_CTL), 1);
    tick(3);
    chk("stop_dac", 32'(dac), 0);
    rd(32'(REG_CTL));
    chk("stop_state", rd_data, 0);

    wr(TBL, 8191);
    wr(32'(REG_AMP), 8192);
    wr(32'(REG_DCO), 100);
    wr(32'(REG_STEP), 0);
    wr(32'(REG_CTL), 2);
    tick(5);
    chk("sat_pos", 32'(dac), 32'h00001fff);
    wr(TBL, 32'h2000);
    tick(4);
    chk("sat_neg", 32'(dac), 32'hffffe000);
    wr(32'(REG_CTL), 1);
    tick(4);
    chk("idle_dco", 32'(dac), 100);

    wr(32'(REG_CTL), 3);
    rd(32'(REG_CTL));
    chk("stop_wins", rd_data, 0);

    wr(32'(REG_TRG), 2);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    rd(32'(REG_CTL));
    chk("ext_trig", rd_data, 1);
    wr(32'(REG_CTL), 1);

    wr(32'(REG_AMP), 4096);
    wr(32'(REG_DCO), 0);
    wr(32'(REG_STEP), 65535);
    wr(32'(REG_OFFS), 32'h50000);
    wr(32'(REG_BDL), 3);
    wr(32'(REG_BIL), 1);
    wr(32'(REG_BRN), 1);
    wr(32'(REG_BURST), 1);
    wr(32'(REG_TRG), 1);
    tick(4);
    wr(32'(REG_CTL), 2);
    for (int e = 1; e <= 14; e++) begin
      tick(1);
      chk($sformatf("burst_e%0d", e), 32'(dac),
          32'(exp_b[e-1]));
    end
    rd(32'(REG_CTL));
    chk("burst_done", rd_data, 0);

    wr(32'(REG_BURST), 0);
    wr(32'(REG_CTL), 2);
    tick(6);
    chk("run_dac", 32'(dac), 8);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dac", 32'(dac), 0);
    @(negedge clk);
    rstn = 1'b1;
    rd(32'(REG_OFFS));
    chk("mid_rst_offs", rd_data, 0);
    rd(32'(REG_CTL));
    chk("mid_rst_state", rd_data, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
